// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the auto-ranging frequency measurement controller.
package freq_meas_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StGate,
    StEval,
    StDone
  } state_e;

  // Gate range encodings; a lower code means a shorter gate.
  localparam logic [1:0] RANGE_10MS  = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_1S    = 2'd2;

  // Divisors applied to the 1 s gate length for each range.
  localparam int unsigned GATE_DIV_1S    = 1;
  localparam int unsigned GATE_DIV_100MS = 10;
  localparam int unsigned GATE_DIV_10MS  = 100;

  function automatic int unsigned gate_div(logic [1:0] rng);
    case (rng)
      RANGE_1S:    return GATE_DIV_1S;
      RANGE_100MS: return GATE_DIV_100MS;
      default:     return GATE_DIV_10MS;
    endcase
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; expire pulses for one cycle when a loaded count reaches zero.
module gate_timer #(
  parameter int unsigned GATE_1S = 100000000,
  localparam int unsigned W      = $clog2(GATE_1S)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;
  // active_q keeps expire from firing repeatedly while the counter idles at zero.
  logic         active_q, active_d;

  // Next count: load wins, otherwise count down until zero then go inactive.
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (load) begin
      count_d  = load_val;
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q - W'(1);
      end
    end
  end

  // Timer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign expire = active_q && (count_q == '0);

endmodule

// File: rtl/freq_meas_ctrl.sv
// Multi-channel auto-ranging frequency measurement controller (1 s / 100 ms / 10 ms gates).
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_1S  = 100000000,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned FREQ_W  = CNT_W + 7,
  localparam int unsigned CH_W    = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] IN,
  input  logic              start,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              continuous,
  output logic              busy,
  output logic              done,
  output logic [FREQ_W-1:0] freq,
  output logic [CH_W-1:0]   freq_ch,
  output logic [1:0]        range,
  output logic              overflow
);

  localparam int unsigned TMR_W = $clog2(GATE_1S);

  logic [NUM_CH-1:0] edge_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sync1_q, sync2_q, last_q;
    // Two-flop synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge CLK) begin
      if (RST) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        sync1_q <= IN[i];
        sync2_q <= sync1_q;
        last_q  <= sync2_q;
      end
    end
    assign edge_vec[i] = sync2_q & ~last_q;
  end

  state_e            state_q, state_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [1:0]        cur_range_q, cur_range_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              ovf_q, ovf_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [CH_W-1:0]   freq_ch_q, freq_ch_d;
  logic [1:0]        range_q, range_d;
  logic              overflow_q, overflow_d;

  logic              tmr_load, tmr_expire;
  logic [TMR_W-1:0]  tmr_load_val;
  logic              edge_sel;
  logic [FREQ_W-1:0] cnt_ext, scaled;

  gate_timer #(
    .GATE_1S (GATE_1S)
  ) u_gate_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expire   (tmr_expire)
  );

  // Shift-add scaling of the raw count to Hz for the current range.
  always_comb begin
    cnt_ext = FREQ_W'(edge_cnt_q);
    case (cur_range_q)
      RANGE_1S:    scaled = cnt_ext;
      RANGE_100MS: scaled = (cnt_ext << 3) + (cnt_ext << 1);
      default:     scaled = (cnt_ext << 6) + (cnt_ext << 5) + (cnt_ext << 2);
    endcase
  end

  // Measurement sequencer: next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    cur_range_d  = cur_range_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_d        = ovf_q;
    freq_d       = freq_q;
    freq_ch_d    = freq_ch_q;
    range_d      = range_q;
    overflow_d   = overflow_q;
    tmr_load     = 1'b0;
    tmr_load_val = TMR_W'(GATE_1S / gate_div(cur_range_q) - 1);
    // Mux after detection so switching channels cannot create a spurious edge.
    edge_sel     = edge_vec[cur_ch_q];

    case (state_q)
      StIdle: begin
        if (start) begin
          cur_ch_d    = ch_sel;
          cur_range_d = RANGE_1S;
          state_d     = StArm;
        end
      end
      StArm: begin
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        tmr_load   = 1'b1;
        state_d    = StGate;
      end
      StGate: begin
        if (edge_sel) begin
          if (edge_cnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        if (tmr_expire) begin
          state_d = StEval;
        end
      end
      StEval: begin
        if (ovf_q && (cur_range_q != RANGE_10MS)) begin
          cur_range_d = cur_range_q - 2'd1;
          state_d     = StArm;
        end else begin
          freq_d     = ovf_q ? '1 : scaled;
          freq_ch_d  = cur_ch_q;
          range_d    = cur_range_q;
          overflow_d = ovf_q;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (continuous) begin
          cur_ch_d    = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
          cur_range_d = RANGE_1S;
          state_d     = StArm;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and result registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cur_ch_q    <= '0;
      cur_range_q <= '0;
      edge_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      freq_q      <= '0;
      freq_ch_q   <= '0;
      range_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      cur_range_q <= cur_range_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      freq_q      <= freq_d;
      freq_ch_q   <= freq_ch_d;
      range_q     <= range_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign freq     = freq_q;
  assign freq_ch  = freq_ch_q;
  assign range    = range_q;
  assign overflow = overflow_q;

endmodule

// File: doc/freq_meas_ctrl.md
# freq_meas_ctrl

Multi-channel, auto-ranging measurement controller for the Pmod frequency-counter path. It synchronises each `IN` channel and detects rising edges. It then schedules gated edge counts on the selected channel, stepping the gate down from 1 s to 100 ms to 10 ms when the counter overflows, and scales the result to Hz. It sits between the Pmod inputs and the display/readout logic, replacing a free-running fixed 1 s counter with a start/done-sequenced measurement engine.

## Interface
- `GATE_1S`, 100000000: CLK cycles in the 1 s gate. Must be a multiple of 100; the 100 ms gate is `GATE_1S/10` and the 10 ms gate is `GATE_1S/100`.
- `NUM_CH`, 2: number of input channels.
- `CNT_W`, 16: edge-counter width. Output width `FREQ_W = CNT_W+7` is a localparam.
- `CLK`  in  1: 100 MHz clock. All logic is on its rising edge.
- `RST`  in  1: reset, synchronous and active-high.
- `IN`  in  NUM_CH: asynchronous Pmod signals.
- `start`  in  1: request a measurement; sampled only in IDLE.
- `ch_sel`  in  clog2(NUM_CH): channel for the first measurement after `start`.
- `continuous`  in  1: when high, measure channels round-robin without stopping.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the result is valid.
- `freq`  out  FREQ_W: last result in Hz.
- `freq_ch`  out  clog2(NUM_CH): channel the result belongs to.
- `range`  out  2: gate used for the result. 2 = 1 s, 1 = 100 ms, 0 = 10 ms.
- `overflow`  out  1: counter overflowed even at the 10 ms gate.

## Operation
- Front end, per channel, always running and independent of state:
  - 2-flop synchroniser, then a `last` flop.
  - `edge[i] = sync[i] & ~last[i]`.
  - The edge of the current channel is muxed after detection, so a channel switch never fabricates an edge.
- FSM states: IDLE, ARM, GATE, EVAL, DONE.
  - IDLE: on `start`, capture `ch_sel` into `cur_ch`, set `cur_range = 2`, go to ARM.
  - ARM, 1 cycle: clear `edge_cnt` and `ovf`, load the gate timer with `G(cur_range)-1`, go to GATE.
  - GATE, exactly `G` cycles: each selected edge increments `edge_cnt`. At all-ones, `edge_cnt` saturates and sets `ovf`. Leave on timer expire.
  - EVAL, 1 cycle:
    - If `ovf` and `cur_range > 0`: decrement `cur_range`, go to ARM. The channel is unchanged.
    - Otherwise: register `freq`, `freq_ch`, `range`, `overflow`, and go to DONE.
  - DONE, 1 cycle: `done = 1`.
    - If `continuous`: `cur_ch = (cur_ch+1) mod NUM_CH`, `cur_range = 2`, go to ARM.
    - Else go to IDLE.
- Scaling, shift-add only, no multiplier:
  - Range 2: ×1.
  - Range 1: ×10 = `(c<<3)+(c<<1)`.
  - Range 0: ×100 = `(c<<6)+(c<<5)+(c<<2)`.
  - Zero-extend `c` to FREQ_W first.
- Overflow at range 0: `freq` = all ones, `overflow = 1`. Otherwise `overflow = 0`.
- `start` while busy is ignored. It is not queued.
- `continuous` falling mid-measurement: the current measurement completes, then the FSM goes to IDLE.

## Timing
- Reset values:
  - `busy`, `done`, `freq`, `freq_ch`, `range`, `overflow` = 0.
  - FSM = IDLE.
  - Counters, timer, synchroniser and `last` flops = 0.
- `RST` in any state: next cycle is IDLE with all of the above cleared. No `done` is issued for the aborted measurement.
- With `start` sampled in cycle 0 and no range step:
  - ARM is cycle 1.
  - GATE is cycles 2..G+1.
  - EVAL is cycle G+2.
  - `done` and the new outputs are visible in cycle G+3.
- Each range step adds `G(new)+2` cycles.
- Outputs hold their value until the next EVAL commits.
- Edge detection has 3 cycles of input-to-count latency. Edges in ARM, EVAL or DONE are not counted.
- Continuous mode has 1 ARM cycle of dead time plus EVAL and DONE per measurement.

## Structure
- Package `freq_meas_pkg` holds:
  - The state enum.
  - The range encodings `RANGE_1S`, `RANGE_100MS`, `RANGE_10MS`.
  - The gate-divisor constants.
- Sub-module `gate_timer`: loadable down-counter.
  - Width `$clog2(GATE_1S)`.
  - Inputs `load` and `load_val`.
  - Output `expire`, a 1-cycle pulse when the count reaches 0.
- Synchroniser and edge detect are inline, one generate instance per channel.

## Test plan
- Reset: assert `RST` for 3 cycles with `IN` toggling. All outputs are 0, `busy = 0`, and no `done` appears for 2000 cycles without `start`.
- Single shot: `GATE_1S = 1000`, ch0 square wave with period 20 CLK, `start` with `ch_sel = 0`. Require `done` at cycle 1003, `freq = 50 ±1`, `range = 2`, `freq_ch = 0`.
- Auto-range: `CNT_W = 8`, ch0 period 2 CLK (500 edges per 1 s gate). Require `done` at cycle 1000+3+102, `freq = 500 ±10`, `range = 1`, `overflow = 0`.
- Full overflow: `CNT_W = 2`, period 2 CLK. Require `range = 0`, `overflow = 1`, `freq` = all ones.
- Continuous: ch0 period 20, ch1 period 10, `continuous = 1`. Require alternating `done` pulses with (`freq_ch = 0`, 50) and (`freq_ch = 1`, 100), each 1003 cycles apart.
- Abort and ignore: `start` pulsed while busy leaves the sequence unchanged. `RST` mid-GATE gives IDLE next cycle, `busy = 0`, and no `done`.
